tagged_memory: RTL and testbench

- Behavioural model of the tagged main memory on the CPU's multiplexed address/data bus.
- Holds 2^AW words; each word is 64 data bits plus an 8-bit tag.
- A word address is latched on an address strobe. Subsequent read/write cycles then access the latched address.
- The latched word address is exported so the trace monitor can report memory activity.

---
 rtl/tagged_memory.sv | 145 ++++++++++++++
 tb/tb_tagged_memory.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tagged_memory.sv
// -----------------------------------------------------------------------------
// tagged_memory
//   Behavioural model of the tagged main memory on the CPU's multiplexed
//   address/data bus. 2^AW words, each DW data bits plus a TW-bit tag.
//   An address strobe latches the word address; subsequent read/write
//   cycles use the latched address. An atomic strobe locks the address
//   until the next write, giving read-modify-write on one word. A clear
//   operation walks the whole array writing data 0 / tag INIT_TAG.
//
//   Build option:
//     TMEM_WRITE_THROUGH_EN  defined   : simultaneous rd+wr returns the new
//                                         write data/tag.
//                            undefined : simultaneous rd+wr returns the old
//                                         contents (read-before-write).
//
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   synchronous active-high reset (array contents kept)
//     i_ad      in   DW  address (bits [AW-1:0], with i_astb) or write data
//     i_tag     in   TW  write tag
//     i_astb    in   address strobe
//     i_atomic  in   lock the latched address until the next write
//     i_rd      in   read request (data valid the following cycle)
//     i_wr      in   write request
//     i_clear   in   start full-array clear
//     o_data    out  DW  read data
//     o_tag     out  TW  read tag
//     o_waddr   out  AW  latched word address (for the trace monitor)
//     o_busy    out  clear in progress
// -----------------------------------------------------------------------------
module tagged_memory #(
  parameter int              AW       = 20,
  parameter int              DW       = 64,
  parameter int              TW       = 8,
  parameter logic [TW-1:0]   INIT_TAG = 8'h34
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_ad,
  input  logic [TW-1:0] i_tag,
  input  logic          i_astb,
  input  logic          i_atomic,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic          i_clear,
  output logic [DW-1:0] o_data,
  output logic [TW-1:0] o_tag,
  output logic [AW-1:0] o_waddr,
  output logic          o_busy
);

  localparam int unsigned   DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST  = '1;

  logic [DW-1:0] mem [DEPTH];
  logic [TW-1:0] tag [DEPTH];

  logic          lock;
  logic [AW-1:0] cnt;

  // Qualified bus requests; the clear walk owns the array while busy.
  logic          astb_acc, wr_en, rd_en;
  logic [AW-1:0] rd_addr;

  assign astb_acc = i_astb & ~lock & ~o_busy;
  // A strobe cycle carries an address on the bus, never write data.
  assign wr_en    = i_wr & ~i_astb & ~o_busy;
  assign rd_en    = i_rd & ~o_busy;
  // A read in the strobe cycle already targets the new address.
  assign rd_addr  = astb_acc ? i_ad[AW-1:0] : o_waddr;

  // Single write port shared between the clear walk and bus writes.
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [TW-1:0] mem_wt;

  always_comb begin
    mem_we = wr_en;
    mem_wa = o_waddr;
    mem_wd = i_ad;
    mem_wt = i_tag;
    if (o_busy) begin
      mem_we = 1'b1;
      mem_wa = cnt;
      mem_wd = '0;
      mem_wt = INIT_TAG;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_wa] <= mem_wd;
      tag[mem_wa] <= mem_wt;
    end
  end

  // Read data. Bus write and read share o_waddr when both are active
  // (wr_en excludes a strobe), so the bypass needs no address compare.
  logic [DW-1:0] rd_data;
  logic [TW-1:0] rd_tag;

`ifdef TMEM_WRITE_THROUGH_EN
  assign rd_data = wr_en ? i_ad  : mem[rd_addr];
  assign rd_tag  = wr_en ? i_tag : tag[rd_addr];
`else
  assign rd_data = mem[rd_addr];
  assign rd_tag  = tag[rd_addr];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      o_data  <= '0;
      o_tag   <= '0;
      o_waddr <= '0;
      lock    <= 1'b0;
      o_busy  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (rd_en) begin
        o_data <= rd_data;
        o_tag  <= rd_tag;
      end

      if (astb_acc) begin
        o_waddr <= i_ad[AW-1:0];
        lock    <= i_atomic;
      end else if (wr_en) begin
        lock    <= 1'b0;
      end

      if (o_busy) begin
        cnt <= cnt + AW'(1);
        if (cnt == LAST) o_busy <= 1'b0;
      end

      // A clear request (re)starts the walk from word 0.
      if (i_clear) begin
        o_busy <= 1'b1;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tagged_memory.sv
module tb_tagged_memory;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef TMEM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   i_ad;
  logic [7:0]    i_tag;
  logic          i_astb, i_atomic, i_rd, i_wr, i_clear;
  logic [63:0]   o_data;
  logic [7:0]    o_tag;
  logic [AW-1:0] o_waddr;
  logic          o_busy;

  tagged_memory #(.AW(AW), .DW(64), .TW(8), .INIT_TAG(8'h34)) dut (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
    .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .i_clear(i_clear),
    .o_data(o_data), .o_tag(o_tag), .o_waddr(o_waddr), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays and integers.
  logic [63:0] m_mem [DEPTH];
  logic [7:0]  m_tg  [DEPTH];
  bit          m_known [DEPTH];
  int          m_waddr, m_cidx;
  bit          m_lock, m_busy, m_dk;
  logic [63:0] m_dout;
  logic [7:0]  m_tout;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int a;
    bit acc;
    if (reset) begin
      m_waddr = 0; m_dout = '0; m_tout = '0; m_dk = 1'b1;
      m_lock = 1'b0; m_busy = 1'b0; m_cidx = 0;
    end else if (m_busy) begin
      m_mem[m_cidx] = '0; m_tg[m_cidx] = 8'h34; m_known[m_cidx] = 1'b1;
      if (m_cidx == DEPTH - 1) m_busy = 1'b0;
      m_cidx = (m_cidx + 1) % DEPTH;
      if (i_clear) begin m_busy = 1'b1; m_cidx = 0; end
    end else begin
      acc = i_astb && !m_lock;
      a   = acc ? int'(i_ad[AW-1:0]) : m_waddr;
      if (i_rd) begin
        if (WT && i_wr && !i_astb) begin
          m_dout = i_ad; m_tout = i_tag; m_dk = 1'b1;
        end else begin
          m_dout = m_mem[a]; m_tout = m_tg[a]; m_dk = m_known[a];
        end
      end
      if (i_wr && !i_astb) begin
        m_mem[m_waddr] = i_ad; m_tg[m_waddr] = i_tag; m_known[m_waddr] = 1'b1;
        m_lock = 1'b0;
      end
      if (acc) begin
        m_waddr = int'(i_ad[AW-1:0]);
        m_lock  = i_atomic;
      end
      if (i_clear) begin m_busy = 1'b1; m_cidx = 0; end
    end
  endtask

  task automatic cmp_cycle();
    chk("waddr", 64'(o_waddr), 64'(m_waddr));
    chk("busy", 64'(o_busy), 64'(m_busy));
    if (m_dk) begin
      chk("data", o_data, m_dout);
      chk("tag", 64'(o_tag), 64'(m_tout));
    end
  endtask

  // One clock: model sees the same inputs as the DUT at the edge,
  // outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic drv(input bit astb, input bit atomic, input bit rd, input bit wr,
                     input logic [63:0] ad, input logic [7:0] tg);
    i_astb = astb; i_atomic = atomic; i_rd = rd; i_wr = wr;
    i_ad = ad; i_tag = tg; i_clear = 1'b0;
    step();
  endtask

  initial begin
    int nb;
    for (int k = 0; k < DEPTH; k++) begin
      m_known[k] = 1'b0; m_mem[k] = '0; m_tg[k] = '0;
    end
    m_dk = 1'b0;
    reset = 1'b1; i_ad = '0; i_tag = '0; i_astb = 0; i_atomic = 0;
    i_rd = 0; i_wr = 0; i_clear = 0;
    step(); step();
    chk("rst_waddr", 64'(o_waddr), 64'h0);
    chk("rst_data", o_data, 64'h0);
    chk("rst_tag", 64'(o_tag), 64'h0);
    chk("rst_busy", 64'(o_busy), 64'h0);
    reset = 1'b0;

    // Address latch; outputs stay 0 until a read.
    drv(1, 0, 0, 0, 64'h808c6, 8'h00);
    chk("astb_waddr", 64'(o_waddr), 64'hc6);
    chk("astb_data", o_data, 64'h0);

    // Clear: busy for DEPTH cycles, bus traffic ignored meanwhile.
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    nb = 0;
    while (o_busy && nb < 1000) begin
      i_rd = 1'b1; i_wr = nb[0]; i_astb = nb[1]; i_ad = 64'hdead_beef_0000_0077;
      nb++;
      step();
    end
    chk("clear_cycles", 64'(nb), 64'(DEPTH));
    chk("clear_waddr_held", 64'(o_waddr), 64'hc6);
    drv(0, 0, 1, 0, 64'h0, 8'h00);
    chk("clear_data", o_data, 64'h0);
    chk("clear_tag", 64'(o_tag), 64'h34);

    // Write then read back.
    drv(1, 0, 0, 0, 64'h10, 8'h00);
    drv(0, 0, 0, 1, 64'h0123456789abcdef, 8'h34);
    drv(0, 0, 1, 0, 64'h0, 8'h00);
    chk("wr_rd_data", o_data, 64'h0123456789abcdef);
    chk("wr_rd_tag", 64'(o_tag), 64'h34);

    // Atomic read-modify-write: second strobe ignored until the write.
    drv(1, 1, 0, 0, 64'h20, 8'h00);
    drv(0, 0, 1, 0, 64'h0, 8'h00);
    chk("atom_rd", o_data, 64'h0);
    drv(1, 0, 0, 0, 64'h30, 8'h00);
    chk("atom_locked", 64'(o_waddr), 64'h20);
    drv(0, 0, 0, 1, 64'h55, 8'h77);
    drv(1, 0, 0, 0, 64'h30, 8'h00);
    chk("atom_released", 64'(o_waddr), 64'h30);
    drv(1, 0, 1, 0, 64'h20, 8'h00);
    chk("atom_mem", o_data, 64'h55);
    chk("atom_tag", 64'(o_tag), 64'h77);

    // Upper address bits ignored; strobe+write drops the write.
    drv(1, 0, 0, 0, 64'hFFFF_FFFF_FFF0_0005, 8'h00);
    chk("addr_mask", 64'(o_waddr), 64'h05);
    drv(1, 0, 0, 1, 64'h99, 8'hAA);
    chk("astb_wr_addr", 64'(o_waddr), 64'h99);
    drv(1, 0, 1, 0, 64'h05, 8'h00);
    chk("astb_wr_nowrite", o_data, 64'h0);

    // Simultaneous read and write.
    drv(1, 0, 0, 0, 64'h40, 8'h00);
    drv(0, 0, 0, 1, 64'h11, 8'h01);
    drv(0, 0, 1, 1, 64'h22, 8'h02);
    chk("rdwr_data", o_data, WT ? 64'h22 : 64'h11);
    chk("rdwr_tag", 64'(o_tag), WT ? 64'h02 : 64'h01);
    drv(0, 0, 1, 0, 64'h0, 8'h00);
    chk("rdwr_after", o_data, 64'h22);

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 499) == 0);
      i_astb   = ($urandom_range(0, 3) == 0);
      i_atomic = ($urandom_range(0, 2) == 0);
      i_rd     = ($urandom_range(0, 9) < 4);
      i_wr     = ($urandom_range(0, 9) < 4);
      i_clear  = !m_busy && ($urandom_range(0, 599) == 0);
      i_ad     = {$urandom(), $urandom()};
      i_tag    = 8'($urandom());
      step();
    end
    reset = 1'b0; i_clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
